// File: rtl/final_nios2_proc_oci_dct_packer_if.sv
// Bundled atom-in / frame-out / status signals of the OCI DCT packer.
// The master modport is the packer; the slave modport is the atom source plus trace sink.
interface final_nios2_proc_oci_dct_packer_if #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4
);
  logic                      atom_valid;
  logic [ATOM_W-1:0]         atom_data;
  logic                      atom_ready;
  logic                      end_req;
  logic                      frame_valid;
  logic                      frame_ready;
  logic [ATOM_W*ATOMS-1:0]   frame_data;
  logic [CNT_W-1:0]          frame_count;
  logic [ATOM_W*ATOMS-1:0]   dct_buffer;
  logic [CNT_W-1:0]          dct_count;
  logic                      test_ending;
  logic                      test_has_ended;

  modport master (
    input  atom_valid, atom_data, end_req, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_ending, test_has_ended
  );

  modport slave (
    output atom_valid, atom_data, end_req, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_ending, test_has_ended
  );
endinterface

// File: rtl/final_nios2_proc_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 30-bit buffer, emits full or flushed buffers as
// valid/ready frames, and sequences the end-of-test flush (RUN -> FLUSH -> ENDED).
module final_nios2_proc_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  final_nios2_proc_oci_dct_packer_if.master dct_if
);
  localparam int               BUF_W = ATOM_W * ATOMS;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(ATOMS);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_ENDED = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [BUF_W-1:0] buf_q,     buf_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [BUF_W-1:0] fdata_q,   fdata_d;
  logic [CNT_W-1:0] fcnt_q,    fcnt_d;
  logic             fvalid_q,  fvalid_d;
  logic             ending_q,  ending_d;
  logic             ended_q,   ended_d;

  logic accept, slot_free, xfer, drained;

  // Ready never depends on end_req, so an atom offered alongside end_req still lands.
  assign dct_if.atom_ready = (state_q == ST_RUN) && (cnt_q != FULL);
  assign accept    = dct_if.atom_valid && dct_if.atom_ready;
  assign slot_free = !fvalid_q || dct_if.frame_ready;
  assign xfer      = slot_free &&
                     ((cnt_q == FULL) || ((state_q == ST_FLUSH) && (cnt_q != '0)));
  assign drained   = (cnt_q == '0) && !fvalid_q;

  // NOTE: every output of always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fdata_d  = fdata_q;
    fcnt_d   = fcnt_q;
    fvalid_d = fvalid_q;
    ending_d = ending_q;
    ended_d  = ended_q;

    // Transfer and accept are mutually exclusive: ready is low whenever a transfer can fire.
    if (xfer) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      buf_d = {buf_q[BUF_W-ATOM_W-1:0], dct_if.atom_data};
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (xfer) begin
      fdata_d  = buf_q;
      fcnt_d   = cnt_q;
      fvalid_d = 1'b1;
    end else if (fvalid_q && dct_if.frame_ready) begin
      fvalid_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (dct_if.end_req) begin
          state_d  = ST_FLUSH;
          ending_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (drained) begin
          state_d = ST_ENDED;
          ended_d = 1'b1;
        end
      end
      ST_ENDED: state_d = ST_ENDED;
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      buf_q    <= '0;
      cnt_q    <= '0;
      fdata_q  <= '0;
      fcnt_q   <= '0;
      fvalid_q <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fdata_q  <= fdata_d;
      fcnt_q   <= fcnt_d;
      fvalid_q <= fvalid_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign dct_if.frame_valid    = fvalid_q;
  assign dct_if.frame_data     = fdata_q;
  assign dct_if.frame_count    = fcnt_q;
  assign dct_if.dct_buffer     = buf_q;
  assign dct_if.dct_count      = cnt_q;
  assign dct_if.test_ending    = ending_q;
  assign dct_if.test_has_ended = ended_q;
endmodule
